// File: rtl/wb_arbiter.sv
// rtl/wb_arbiter.sv - writeback arbiter merging ALU and queued mult/div results onto one regfile write port
//
// Ports:
//   clk, rst            clock (rising edge), asynchronous active-low reset
//   alu_valid/addr/data ALU result, no backpressure, always wins arbitration
//   md_valid/ready/addr/data  mult/div result handshake into a DEPTH-entry FIFO
//   ctrl_we/addr_rd/data_rd   registered regfile write port
//   stall_req           registered request to hold ALU issue while the queue starves
//   query_addr/query_hit      combinational pending-write lookup for decode hazards
module wb_arbiter #(
  parameter int DEPTH      = 2,
  parameter int STARVE_LIM = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        alu_valid,
  input  logic [4:0]  alu_addr,
  input  logic [31:0] alu_data,
  input  logic        md_valid,
  output logic        md_ready,
  input  logic [4:0]  md_addr,
  input  logic [31:0] md_data,
  output logic        ctrl_we,
  output logic [4:0]  addr_rd,
  output logic [31:0] data_rd,
  output logic        stall_req,
  input  logic [4:0]  query_addr,
  output logic        query_hit
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int SW = $clog2(STARVE_LIM) + 1;
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIM - 1);

  logic [4:0]    fifo_addr_q [DEPTH];
  logic [31:0]   fifo_data_q [DEPTH];

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q,  count_d;
  logic [SW-1:0] starve_q, starve_d;
  logic          stall_q,  stall_d;
  logic          we_q,     we_d;
  logic [4:0]    addr_q,   addr_d;
  logic [31:0]   data_q,   data_d;

  logic          full;
  logic          empty;
  logic          enq;
  logic          alu_win;
  logic          pop;
  logic [PW-1:0] off;
  logic          qhit;

  assign full     = (count_q == CW'(DEPTH));
  assign empty    = (count_q == '0);
  assign md_ready = !full;

  // r0 beats complete the handshake but never occupy a slot.
  assign enq      = md_valid && md_ready && (md_addr != 5'd0);
  assign alu_win  = alu_valid && (alu_addr != 5'd0);
  // Pop decision uses the pre-edge head, so an empty queue is never bypassed.
  assign pop      = !alu_win && !empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (enq) wr_ptr_d = wr_ptr_q + PW'(1);
    if (pop) rd_ptr_d = rd_ptr_q + PW'(1);
    count_d = count_q + CW'(enq) - CW'(pop);
  end

  always_comb begin
    we_d   = 1'b0;
    addr_d = addr_q;
    data_d = data_q;
    if (alu_win) begin
      we_d   = 1'b1;
      addr_d = alu_addr;
      data_d = alu_data;
    end else if (pop) begin
      we_d   = 1'b1;
      addr_d = fifo_addr_q[rd_ptr_q];
      data_d = fifo_data_q[rd_ptr_q];
    end
  end

  // The counter saturates at STARVE_MAX; one more blocked cycle raises stall_req.
  always_comb begin
    starve_d = starve_q;
    stall_d  = stall_q;
    if (empty || pop) begin
      starve_d = '0;
      stall_d  = 1'b0;
    end else if (alu_win) begin
      if (starve_q == STARVE_MAX) stall_d = 1'b1;
      else                        starve_d = starve_q + SW'(1);
    end
  end

  // An entry is live when its distance from the read pointer is below occupancy.
  always_comb begin
    qhit = 1'b0;
    off  = '0;
    for (int i = 0; i < DEPTH; i++) begin
      off = PW'(i) - rd_ptr_q;
      if ((CW'(off) < count_q) && (fifo_addr_q[i] == query_addr)) qhit = 1'b1;
    end
    if (we_q && (addr_q == query_addr)) qhit = 1'b1;
    query_hit = qhit && (query_addr != 5'd0);
  end

  always_ff @(posedge clk) begin
    if (enq) begin
      fifo_addr_q[wr_ptr_q] <= md_addr;
      fifo_data_q[wr_ptr_q] <= md_data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      starve_q <= '0;
      stall_q  <= 1'b0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      data_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      starve_q <= starve_d;
      stall_q  <= stall_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
    end
  end

  assign ctrl_we   = we_q;
  assign addr_rd   = addr_q;
  assign data_rd   = data_q;
  assign stall_req = stall_q;

endmodule

// File: tb/tb_wb_arbiter.sv
// tb/tb_wb_arbiter.sv - directed self-checking bench for wb_arbiter
module tb_wb_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        alu_valid;
  logic [4:0]  alu_addr;
  logic [31:0] alu_data;
  logic        md_valid;
  logic        md_ready;
  logic [4:0]  md_addr;
  logic [31:0] md_data;
  logic        ctrl_we;
  logic [4:0]  addr_rd;
  logic [31:0] data_rd;
  logic        stall_req;
  logic [4:0]  query_addr;
  logic        query_hit;

  int n_checks = 0;
  int n_fail   = 0;

  wb_arbiter #(.DEPTH(2), .STARVE_LIM(4)) dut (
    .clk(clk), .rst(rst),
    .alu_valid(alu_valid), .alu_addr(alu_addr), .alu_data(alu_data),
    .md_valid(md_valid), .md_ready(md_ready), .md_addr(md_addr), .md_data(md_data),
    .ctrl_we(ctrl_we), .addr_rd(addr_rd), .data_rd(data_rd),
    .stall_req(stall_req), .query_addr(query_addr), .query_hit(query_hit)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Upstream must not issue ALU results while stall_req is high.
  always @(posedge clk) begin
    if (rst && stall_req) check_eq("stall_obeyed", {31'd0, alu_valid}, 32'd0);
  end

  initial begin
    rst = 1'b0;
    alu_valid = 1'b1; alu_addr = 5'd3; alu_data = 32'h11;
    md_valid = 1'b1; md_addr = 5'd4; md_data = 32'h44;
    query_addr = 5'd4;

    // Reset held with active inputs
    tick(); tick();
    check_eq("rst_we", {31'd0, ctrl_we}, 32'd0);
    check_eq("rst_addr", {27'd0, addr_rd}, 32'd0);
    check_eq("rst_data", data_rd, 32'd0);
    check_eq("rst_stall", {31'd0, stall_req}, 32'd0);
    check_eq("rst_ready", {31'd0, md_ready}, 32'd1);
    check_eq("rst_qhit", {31'd0, query_hit}, 32'd0);

    // Release: first ALU beat visible next cycle
    rst = 1'b1; md_valid = 1'b0;
    tick();
    check_eq("rel_we", {31'd0, ctrl_we}, 32'd1);
    check_eq("rel_addr", {27'd0, addr_rd}, 32'd3);
    check_eq("rel_data", data_rd, 32'h11);

    // ALU only
    alu_addr = 5'd5; alu_data = 32'hDEADBEEF;
    tick();
    check_eq("alu_we", {31'd0, ctrl_we}, 32'd1);
    check_eq("alu_addr", {27'd0, addr_rd}, 32'd5);
    check_eq("alu_data", data_rd, 32'hDEADBEEF);
    alu_addr = 5'd0; alu_data = 32'h55;
    tick();
    check_eq("alu_r0_we", {31'd0, ctrl_we}, 32'd0);
    check_eq("alu_r0_hold_addr", {27'd0, addr_rd}, 32'd5);
    check_eq("alu_r0_hold_data", data_rd, 32'hDEADBEEF);
    alu_valid = 1'b0;

    // Mult/div alone: two-cycle latency through the queue
    md_valid = 1'b1; md_addr = 5'd7; md_data = 32'h1234; query_addr = 5'd7;
    #1;
    check_eq("md_qhit_same_cycle", {31'd0, query_hit}, 32'd0);
    tick();
    md_valid = 1'b0;
    #1;
    check_eq("md_n1_we", {31'd0, ctrl_we}, 32'd0);
    check_eq("md_n1_qhit", {31'd0, query_hit}, 32'd1);
    tick();
    check_eq("md_n2_we", {31'd0, ctrl_we}, 32'd1);
    check_eq("md_n2_addr", {27'd0, addr_rd}, 32'd7);
    check_eq("md_n2_data", data_rd, 32'h1234);
    check_eq("md_n2_qhit", {31'd0, query_hit}, 32'd1);
    tick();
    check_eq("md_n3_we", {31'd0, ctrl_we}, 32'd0);
    check_eq("md_n3_qhit", {31'd0, query_hit}, 32'd0);

    // Contention: ALU busy every cycle while r8, r9 queue up
    alu_valid = 1'b1; alu_addr = 5'd10; alu_data = 32'hA0;
    md_valid = 1'b1; md_addr = 5'd8; md_data = 32'h8888;
    #1;
    check_eq("ct_ready0", {31'd0, md_ready}, 32'd1);
    tick();
    md_addr = 5'd9; md_data = 32'h9999; alu_data = 32'hA1;
    #1;
    check_eq("ct_ready1", {31'd0, md_ready}, 32'd1);
    tick();
    md_valid = 1'b0;
    check_eq("ct_full", {31'd0, md_ready}, 32'd0);
    check_eq("ct_alu_addr", {27'd0, addr_rd}, 32'd10);
    check_eq("ct_alu_data", data_rd, 32'hA1);
    check_eq("ct_stall_a", {31'd0, stall_req}, 32'd0);
    tick();
    check_eq("ct_stall_b", {31'd0, stall_req}, 32'd0);
    tick();
    check_eq("ct_stall_c", {31'd0, stall_req}, 32'd0);
    tick();
    check_eq("ct_stall_d", {31'd0, stall_req}, 32'd1);
    check_eq("ct_still_alu", {27'd0, addr_rd}, 32'd10);
    alu_valid = 1'b0;
    tick();
    check_eq("ct_pop8_we", {31'd0, ctrl_we}, 32'd1);
    check_eq("ct_pop8_addr", {27'd0, addr_rd}, 32'd8);
    check_eq("ct_pop8_data", data_rd, 32'h8888);
    check_eq("ct_stall_clr", {31'd0, stall_req}, 32'd0);
    check_eq("ct_ready_back", {31'd0, md_ready}, 32'd1);
    tick();
    check_eq("ct_pop9_addr", {27'd0, addr_rd}, 32'd9);
    check_eq("ct_pop9_data", data_rd, 32'h9999);
    tick();
    check_eq("ct_idle_we", {31'd0, ctrl_we}, 32'd0);

    // r0 filter: handshake completes, slot not consumed
    md_valid = 1'b1; md_addr = 5'd0; md_data = 32'hFFFF; query_addr = 5'd0;
    alu_valid = 1'b1; alu_addr = 5'd11; alu_data = 32'hB0;
    #1;
    check_eq("r0_ready", {31'd0, md_ready}, 32'd1);
    check_eq("r0_qhit", {31'd0, query_hit}, 32'd0);
    tick();
    md_addr = 5'd12; md_data = 32'hC12;
    tick();
    md_addr = 5'd13; md_data = 32'hC13;
    #1;
    check_eq("r0_not_queued", {31'd0, md_ready}, 32'd1);
    tick();
    md_valid = 1'b0; alu_valid = 1'b0; query_addr = 5'd12;
    #1;
    check_eq("mid_full", {31'd0, md_ready}, 32'd0);
    check_eq("mid_qhit12", {31'd0, query_hit}, 32'd1);

    // Reset mid-operation with two queued entries
    rst = 1'b0;
    #1;
    check_eq("mid_rst_ready", {31'd0, md_ready}, 32'd1);
    check_eq("mid_rst_we", {31'd0, ctrl_we}, 32'd0);
    check_eq("mid_rst_qhit", {31'd0, query_hit}, 32'd0);
    tick();
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_eq("post_rst_no_write", {31'd0, ctrl_we}, 32'd0);
    end
    check_eq("post_rst_addr", {27'd0, addr_rd}, 32'd0);
    check_eq("post_rst_ready", {31'd0, md_ready}, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/wb_arbiter.md
Name: wb_arbiter

Overview:
- Writeback stage directly upstream of the register file write port.
- Merges two result producers onto the single write port (ctrl_we/addr_rd/data_rd):
  - the single-cycle ALU pipeline, which always wins;
  - the multi-cycle mult/div unit, whose results are buffered in a small FIFO until a free slot.
- Provides a hazard query so decode can stall on destinations still queued.

Parameters:
- DEPTH, 2, mult/div result queue entries (power of two, >= 2).
- STARVE_LIM, 4, consecutive cycles the queue head may be blocked by the ALU before stall_req asserts (>= 1).

Ports:
- clk  in  1  clock, all state on rising edge.
- rst  in  1  asynchronous, active-low reset.
- alu_valid  in  1  ALU result valid this cycle; no backpressure.
- alu_addr  in  5  ALU destination register.
- alu_data  in  32  ALU result.
- md_valid  in  1  mult/div result offered.
- md_ready  out  1  queue can accept; = !full.
- md_addr  in  5  mult/div destination register.
- md_data  in  32  mult/div result.
- ctrl_we  out  1  registered write enable to regfile.
- addr_rd  out  5  registered write address.
- data_rd  out  32  registered write data.
- stall_req  out  1  registered; asks upstream to hold ALU issue.
- query_addr  in  5  decode source/dest register to check.
- query_hit  out  1  combinational; query_addr has a pending write.

Behaviour:

Reset:
- While rst=0: queue empty, starve counter 0, ctrl_we=0, addr_rd=0, data_rd=0, stall_req=0. md_ready=1.
- Reset mid-operation discards all queued entries and any pending output write.

Queue:
- Enqueue on md_valid && md_ready, except md_addr==0: handshake completes but the entry is dropped (r0 is never written).
- md_ready depends on full only. A full queue that pops this cycle still shows md_ready=0 this cycle.
- Pointers wrap modulo DEPTH. Occupancy counter is 0..DEPTH.

Arbitration, evaluated each cycle from the current-cycle inputs and the queue head before that edge's enqueue:
- alu_valid && alu_addr!=0: output registers load {1, alu_addr, alu_data}; head not popped.
- Otherwise, queue non-empty: pop head, output registers load {1, head.addr, head.data}.
- Otherwise: ctrl_we<=0; addr_rd and data_rd hold their values.
- ALU with alu_addr==0 counts as no ALU write, so the queue may drain that cycle.

Latency and ordering:
- ALU result at cycle N appears on the write port in cycle N+1.
- Mult/div minimum latency is 2: enqueue at edge N, pop at edge N+1, write visible N+2. No bypass of an empty queue.
- Queue is FIFO. No reordering among mult/div results.

Starvation:
- Counter increments each cycle the queue is non-empty and the ALU wins.
- Counter clears on any pop or when the queue is empty.
- stall_req<=1 when counter reaches STARVE_LIM-1 and the ALU wins again. stall_req<=0 on the cycle after a pop.
- While stall_req=1 upstream must keep alu_valid=0. A violation is still honoured (ALU wins) and is flagged by a bench assertion.

query_hit:
- Equals 1 iff query_addr!=0 and query_addr matches any valid queue entry, or (ctrl_we && addr_rd==query_addr).
- An md beat enqueuing this same cycle is not included.

Simultaneous events:
- Enqueue and pop in the same cycle keep the count unchanged. With DEPTH=2 and count 1, the head pops and the new entry becomes the head.

Test Plan:
- Reset: hold rst=0 with active inputs → all outputs 0, md_ready=1. Release rst → first ALU beat {r3, 0x11} appears next cycle.
- ALU only: alu_valid with r5=0xDEADBEEF at N → ctrl_we=1, addr_rd=5, data_rd=0xDEADBEEF at N+1. Then alu_addr=0 → ctrl_we=0.
- Mult/div alone: md r7=0x1234 at N → write r7 at N+2. query_hit=1 for query_addr=7 during N+1..N+2, 0 at N+3.
- Contention: md r8, r9 enqueued while ALU writes every cycle → md_ready=0 after 2 accepts. stall_req=1 after 4 blocked cycles. ALU idles → r8 then r9 written in order, stall_req clears.
- r0 filter: md r0=0xFFFF handshake completes → no write ever, count unchanged, query_hit(0)=0.
- Reset mid-operation: queue holding 2 entries, assert rst → queue empties, no stale writes after release, md_ready=1.
